// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: registers execute results, drives req/gnt/rvalid bus, aligns and extends data
// One write-back record per accepted instruction; upstream is stalled while a bus transaction is open.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_regcData,
  input  logic [4:0]        ex_regcAddr,
  input  logic              ex_regcWr,
  input  logic [31:0]       ex_memAddr,
  input  logic [31:0]       ex_memData,
  input  logic              ex_readWr,
  input  logic              ex_writeWr,
  input  logic [3:0]        ex_rmask,
  input  logic [3:0]        ex_wmask,
  input  logic              ex_ld_unsigned,
  output logic              mem_busy,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [31:0]       dbus_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_regcAddr,
  output logic              wb_regcWr,
  output logic [31:0]       wb_regcData,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e              state_q, state_d;
  logic [31:0]         regc_data_q, regc_data_d;
  logic [4:0]          regc_addr_q, regc_addr_d;
  logic                regc_wr_q, regc_wr_d;
  logic [1:0]          off_q, off_d;
  size_e               size_q, size_d;
  logic                ld_unsigned_q, ld_unsigned_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [3:0]          req_be_q, req_be_d;
  logic [31:0]         req_wdata_q, req_wdata_d;
  logic                req_we_q, req_we_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_addr_q, wb_addr_d;
  logic                wb_wr_q, wb_wr_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d;

  logic                cap_is_store;
  logic                cap_is_mem;
  logic [3:0]          cap_mask;
  size_e               cap_size;
  logic                cap_misaligned;
  logic [3:0]          cap_be;
  logic [31:0]         cap_wdata;
  logic [31:0]         ld_shift;
  logic [31:0]         ld_data;

  // Store wins when both load and store flags are set.
  always_comb begin
    cap_is_store = ex_writeWr;
    cap_is_mem   = ex_readWr | ex_writeWr;
    cap_mask     = cap_is_store ? ex_wmask : ex_rmask;
    if (cap_mask == 4'b1111)      cap_size = SZ_W;
    else if (cap_mask == 4'b0011) cap_size = SZ_H;
    else                          cap_size = SZ_B;
    cap_misaligned = cap_is_mem &&
                     (((cap_size == SZ_H) && ex_memAddr[0]) ||
                      ((cap_size == SZ_W) && (ex_memAddr[1:0] != 2'b00)));
    cap_be = cap_mask << ex_memAddr[1:0];
    case (cap_size)
      SZ_B:    cap_wdata = {4{ex_memData[7:0]}};
      SZ_H:    cap_wdata = {2{ex_memData[15:0]}};
      default: cap_wdata = ex_memData;
    endcase
  end

  always_comb begin
    ld_shift = dbus_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    ld_data = {{24{~ld_unsigned_q & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    regc_data_d   = regc_data_q;
    regc_addr_d   = regc_addr_q;
    regc_wr_d     = regc_wr_q;
    off_d         = off_q;
    size_d        = size_q;
    ld_unsigned_d = ld_unsigned_q;
    req_addr_d    = req_addr_q;
    req_be_d      = req_be_q;
    req_wdata_d   = req_wdata_q;
    req_we_d      = req_we_q;
    wb_valid_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_wr_d       = wb_wr_q;
    wb_data_d     = wb_data_q;
    misalign_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          regc_data_d   = ex_regcData;
          regc_addr_d   = ex_regcAddr;
          regc_wr_d     = ex_regcWr;
          off_d         = ex_memAddr[1:0];
          size_d        = cap_size;
          ld_unsigned_d = ex_ld_unsigned;
          if (!cap_is_mem || cap_misaligned) begin
            // Pass-through or dropped misaligned access retires immediately.
            wb_valid_d = 1'b1;
            wb_addr_d  = ex_regcAddr;
            wb_wr_d    = ex_regcWr & ~cap_misaligned;
            wb_data_d  = ex_regcData;
            misalign_d = cap_misaligned;
          end else begin
            state_d     = REQ;
            req_addr_d  = {ex_memAddr[ADDR_W-1:2], 2'b00};
            req_be_d    = cap_be;
            req_wdata_d = cap_is_store ? cap_wdata : 32'h0;
            req_we_d    = cap_is_store;
          end
        end
      end
      REQ: begin
        if (dbus_gnt) begin
          if (req_we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_addr_d  = regc_addr_q;
            wb_wr_d    = regc_wr_q;
            wb_data_d  = regc_data_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dbus_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_addr_d  = regc_addr_q;
          wb_wr_d    = regc_wr_q;
          wb_data_d  = ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      regc_data_q   <= 32'h0;
      regc_addr_q   <= 5'h0;
      regc_wr_q     <= 1'b0;
      off_q         <= 2'b00;
      size_q        <= SZ_B;
      ld_unsigned_q <= 1'b0;
      req_addr_q    <= '0;
      req_be_q      <= 4'h0;
      req_wdata_q   <= 32'h0;
      req_we_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= 5'h0;
      wb_wr_q       <= 1'b0;
      wb_data_q     <= 32'h0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      regc_data_q   <= regc_data_d;
      regc_addr_q   <= regc_addr_d;
      regc_wr_q     <= regc_wr_d;
      off_q         <= off_d;
      size_q        <= size_d;
      ld_unsigned_q <= ld_unsigned_d;
      req_addr_q    <= req_addr_d;
      req_be_q      <= req_be_d;
      req_wdata_q   <= req_wdata_d;
      req_we_q      <= req_we_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_wr_q       <= wb_wr_d;
      wb_data_q     <= wb_data_d;
      misalign_q    <= misalign_d;
    end
  end

  assign mem_busy    = (state_q != IDLE);
  assign dbus_req    = (state_q == REQ);
  assign dbus_we     = req_we_q;
  assign dbus_addr   = req_addr_q;
  assign dbus_be     = req_be_q;
  assign dbus_wdata  = req_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_regcAddr = wb_addr_q;
  assign wb_regcWr   = wb_wr_q;
  assign wb_regcData = wb_data_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_regcData;
  logic [4:0]  ex_regcAddr;
  logic        ex_regcWr;
  logic [31:0] ex_memAddr;
  logic [31:0] ex_memData;
  logic        ex_readWr;
  logic        ex_writeWr;
  logic [3:0]  ex_rmask;
  logic [3:0]  ex_wmask;
  logic        ex_ld_unsigned;
  logic        mem_busy;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_regcAddr;
  logic        wb_regcWr;
  logic [31:0] wb_regcData;
  logic        misalign;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_regcData(ex_regcData), .ex_regcAddr(ex_regcAddr),
    .ex_regcWr(ex_regcWr), .ex_memAddr(ex_memAddr), .ex_memData(ex_memData),
    .ex_readWr(ex_readWr), .ex_writeWr(ex_writeWr), .ex_rmask(ex_rmask),
    .ex_wmask(ex_wmask), .ex_ld_unsigned(ex_ld_unsigned),
    .mem_busy(mem_busy), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_regcAddr(wb_regcAddr), .wb_regcWr(wb_regcWr),
    .wb_regcData(wb_regcData), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_regcData = 0; ex_regcAddr = 0; ex_regcWr = 0;
    ex_memAddr = 0; ex_memData = 0; ex_readWr = 0; ex_writeWr = 0;
    ex_rmask = 0; ex_wmask = 0; ex_ld_unsigned = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"}, 32'(dbus_req), 32'h0);
    check({tag, " we"}, 32'(dbus_we), 32'h0);
    check({tag, " addr"}, dbus_addr, 32'h0);
    check({tag, " be"}, 32'(dbus_be), 32'h0);
    check({tag, " wdata"}, dbus_wdata, 32'h0);
    check({tag, " wb_valid"}, 32'(wb_valid), 32'h0);
    check({tag, " wb_addr"}, 32'(wb_regcAddr), 32'h0);
    check({tag, " wb_wr"}, 32'(wb_regcWr), 32'h0);
    check({tag, " wb_data"}, wb_regcData, 32'h0);
    check({tag, " misalign"}, 32'(misalign), 32'h0);
    check({tag, " busy"}, 32'(mem_busy), 32'h0);
  endtask

  task automatic pass_through(input logic [31:0] data, input logic [4:0] ra, input logic wr);
    ex_valid = 1; ex_regcData = data; ex_regcAddr = ra; ex_regcWr = wr;
    tick();
    check("pt wb_valid", 32'(wb_valid), 32'h1);
    check("pt wb_data", wb_regcData, data);
    check("pt wb_addr", 32'(wb_regcAddr), 32'(ra));
    check("pt wb_wr", 32'(wb_regcWr), 32'(wr));
    check("pt no req", 32'(dbus_req), 32'h0);
  endtask

  // Store: gdly cycles of withheld grant, then grant; wb_valid the cycle after grant.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wmask,
                          input logic also_read, input int gdly,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    clear_ex();
    ex_valid = 1; ex_memAddr = addr; ex_memData = data; ex_wmask = wmask;
    ex_rmask = 4'b0001; ex_writeWr = 1; ex_readWr = also_read;
    ex_regcAddr = 5'd3; ex_regcData = 32'h5555_AAAA;
    tick();
    clear_ex();
    for (int i = 0; i <= gdly; i++) begin
      check("st req", 32'(dbus_req), 32'h1);
      check("st addr", dbus_addr, exp_addr);
      check("st be", 32'(dbus_be), 32'(exp_be));
      check("st wdata", dbus_wdata, exp_wdata);
      check("st we", 32'(dbus_we), 32'h1);
      check("st busy", 32'(mem_busy), 32'h1);
      check("st no wb yet", 32'(wb_valid), 32'h0);
      if (i == gdly) dbus_gnt = 1;
      tick();
    end
    dbus_gnt = 0;
    check("st wb_valid", 32'(wb_valid), 32'h1);
    check("st wb_wr", 32'(wb_regcWr), 32'h0);
    check("st busy drop", 32'(mem_busy), 32'h0);
    check("st req drop", 32'(dbus_req), 32'h0);
    tick();
    check("st wb pulse", 32'(wb_valid), 32'h0);
  endtask

  // Load: gdly withheld-grant cycles, then rdly WAIT cycles before rvalid.
  task automatic do_load(input logic [31:0] addr, input logic [3:0] rmask, input logic uns,
                         input logic [31:0] rdata, input int gdly, input int rdly,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp);
    clear_ex();
    ex_valid = 1; ex_memAddr = addr; ex_rmask = rmask; ex_readWr = 1;
    ex_ld_unsigned = uns; ex_regcAddr = 5'd7; ex_regcWr = 1;
    tick();
    clear_ex();
    for (int i = 0; i <= gdly; i++) begin
      check("ld req", 32'(dbus_req), 32'h1);
      check("ld addr", dbus_addr, exp_addr);
      check("ld be", 32'(dbus_be), 32'(exp_be));
      check("ld we", 32'(dbus_we), 32'h0);
      check("ld busy", 32'(mem_busy), 32'h1);
      if (i == gdly) dbus_gnt = 1;
      tick();
    end
    dbus_gnt = 0;
    for (int i = 0; i <= rdly; i++) begin
      check("ld wait busy", 32'(mem_busy), 32'h1);
      check("ld wait no req", 32'(dbus_req), 32'h0);
      check("ld wait no wb", 32'(wb_valid), 32'h0);
      if (i == rdly) begin
        dbus_rvalid = 1; dbus_rdata = rdata;
      end
      tick();
    end
    dbus_rvalid = 0; dbus_rdata = 32'h0;
    check("ld wb_valid", 32'(wb_valid), 32'h1);
    check("ld wb_data", wb_regcData, exp);
    check("ld wb_addr", 32'(wb_regcAddr), 32'd7);
    check("ld wb_wr", 32'(wb_regcWr), 32'h1);
    check("ld busy drop", 32'(mem_busy), 32'h0);
  endtask

  task automatic do_misaligned(input logic [31:0] addr, input logic [3:0] mask, input logic store);
    clear_ex();
    ex_valid = 1; ex_memAddr = addr; ex_rmask = mask; ex_wmask = mask;
    ex_readWr = ~store; ex_writeWr = store; ex_regcAddr = 5'd9; ex_regcWr = 1;
    tick();
    clear_ex();
    check("mis flag", 32'(misalign), 32'h1);
    check("mis wb_valid", 32'(wb_valid), 32'h1);
    check("mis wb_wr", 32'(wb_regcWr), 32'h0);
    check("mis no req", 32'(dbus_req), 32'h0);
    check("mis busy", 32'(mem_busy), 32'h0);
    tick();
    check("mis pulse", 32'(misalign), 32'h0);
    check("mis no req later", 32'(dbus_req), 32'h0);
  endtask

  initial begin
    rst = 1; dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 32'h0;
    clear_ex();
    tick(); tick();
    check_all_zero("reset");
    rst = 0;
    tick();

    pass_through(32'h0000_1234, 5'd5, 1'b1);
    pass_through(32'hFFFF_0001, 5'd31, 1'b0);
    clear_ex();
    tick();
    check("pt wb pulse", 32'(wb_valid), 32'h0);
    check("pt hold data", wb_regcData, 32'hFFFF_0001);

    do_store(32'h0000_0103, 32'h0000_00AB, 4'b0001, 1'b0, 0, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    do_store(32'h0000_0106, 32'h1234_BEEF, 4'b0011, 1'b0, 2, 32'h0000_0104, 4'b1100, 32'hBEEF_BEEF);
    do_store(32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 1'b1, 1, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D);

    do_load(32'h0000_0102, 4'b0001, 1'b0, 32'h0080_0000, 0, 0, 32'h0000_0100, 4'b0100, 32'hFFFF_FF80);
    do_load(32'h0000_0102, 4'b0001, 1'b1, 32'h0080_0000, 0, 0, 32'h0000_0100, 4'b0100, 32'h0000_0080);
    do_load(32'h0000_0202, 4'b0011, 1'b0, 32'h8001_0000, 3, 1, 32'h0000_0200, 4'b1100, 32'hFFFF_8001);
    do_load(32'h0000_0202, 4'b0011, 1'b1, 32'h8001_0000, 0, 0, 32'h0000_0200, 4'b1100, 32'h0000_8001);
    do_load(32'h0000_0101, 4'b0001, 1'b0, 32'h0000_7F00, 0, 0, 32'h0000_0100, 4'b0010, 32'h0000_007F);
    do_load(32'h0000_0300, 4'b1111, 1'b0, 32'hDEAD_BEEF, 1, 2, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF);

    do_misaligned(32'h0000_0101, 4'b1111, 1'b0);
    do_misaligned(32'h0000_0103, 4'b0011, 1'b1);

    // Reset while a load sits in WAIT; the late rvalid must be ignored.
    clear_ex();
    ex_valid = 1; ex_memAddr = 32'h0000_0500; ex_rmask = 4'b1111; ex_readWr = 1; ex_regcWr = 1;
    tick();
    clear_ex();
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0;
    check("wait busy", 32'(mem_busy), 32'h1);
    rst = 1;
    tick();
    rst = 0;
    check_all_zero("rst in wait");
    dbus_rvalid = 1; dbus_rdata = 32'h1111_2222;
    tick();
    dbus_rvalid = 0;
    check("late rvalid wb", 32'(wb_valid), 32'h0);
    check("late rvalid busy", 32'(mem_busy), 32'h0);
    check("late rvalid data", wb_regcData, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage sitting directly downstream of the execute stage, in front of write-back. It registers the execute-stage result and memory request, then drives a req/gnt/rvalid data bus. It aligns store data and byte-enables, and extracts and extends load data. It stalls upstream while a bus transaction is outstanding and delivers one write-back record per accepted instruction.

## Interface
Parameters:
- ADDR_W, 32, data-bus address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute stage presents an instruction this cycle
- ex_regcData  in  32  ALU / HI / LO result
- ex_regcAddr  in  5  destination register
- ex_regcWr  in  1  register write enable
- ex_memAddr  in  32  byte address for load/store
- ex_memData  in  32  store data, right-justified
- ex_readWr  in  1  load
- ex_writeWr  in  1  store
- ex_rmask  in  4  load size: 4'b0001 byte, 4'b0011 half, 4'b1111 word (unshifted)
- ex_wmask  in  4  store size, same encoding
- ex_ld_unsigned  in  1  zero-extend load (LBU/LHU)
- mem_busy  out  1  stall to upstream; ex_valid is ignored while high
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-aligned write data
- dbus_gnt  in  1  request accepted this cycle
- dbus_rvalid  in  1  read data valid
- dbus_rdata  in  32  read data
- wb_valid  out  1  write-back record valid (one-cycle pulse)
- wb_regcAddr  out  5  destination register
- wb_regcWr  out  1  register write enable
- wb_regcData  out  32  final write data
- misalign  out  1  one-cycle pulse: access was misaligned and dropped

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, ex_valid=1:
  - All ex_* fields are captured.
  - Load or store goes to REQ; otherwise the instruction completes as a pass-through.
- Capture with ex_readWr=ex_writeWr=1: treated as a store.
- Alignment check at capture:
  - Half with addr[0]=1: misaligned.
  - Word with addr[1:0]≠0: misaligned.
  - Misaligned access: no bus request; next cycle wb_valid=1, wb_regcWr=0, misalign=1; state stays IDLE.
- REQ:
  - dbus_req=1; dbus_addr, dbus_we, dbus_be, dbus_wdata held stable until dbus_gnt.
  - Store: be = mask<<addr[1:0]; wdata = data replicated to lanes (byte ×4, half ×2).
  - Load: be = rmask<<addr[1:0], we=0.
- REQ→IDLE on gnt for a store: wb_valid the next cycle, with wb_regcWr as captured (normally 0).
- REQ→WAIT on gnt for a load.
- WAIT→IDLE on dbus_rvalid:
  - rdata shifted right by 8·addr[1:0], masked to size.
  - Sign-extended unless ex_ld_unsigned.
  - Result goes to wb_regcData; wb_valid=1 the next cycle.
  - dbus_rvalid in IDLE or REQ is ignored.
- Pass-through: wb_regcData = ex_regcData.
- mem_busy = (state≠IDLE).
- Reset:
  - State returns to IDLE; any in-flight transaction is abandoned and a late rvalid is ignored.
  - All outputs are 0: dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_valid, wb_regcAddr, wb_regcWr, wb_regcData, misalign, mem_busy.

## Timing
- Pass-through: wb_valid exactly 1 cycle after capture; a new capture is possible every cycle.
- Store: dbus_req asserts the cycle after capture. With gnt in that same cycle, wb_valid comes 2 cycles after capture.
- Load: minimum latency is capture → req (+1) → gnt same cycle → rvalid (+1) → wb_valid (+1), i.e. 3 cycles.
- mem_busy is high from the cycle after a memory capture up to and including the cycle rvalid or gnt (store) is seen.
- Upstream may present a new instruction the cycle mem_busy drops.
- wb_valid and misalign are single-cycle pulses; wb_* fields hold their values until the next wb_valid.
- Gnt may be withheld indefinitely: dbus_req and all request fields stay stable.

## Test plan
- Pass-through: ex_regcData=0x1234, regcAddr=5, regcWr=1 → next cycle wb_valid=1, wb_regcData=0x1234, wb_regcAddr=5, dbus_req never asserted.
- Store byte: addr=0x103, data=0xAB, wmask=0001, gnt immediate → dbus_addr=0x100, be=1000, wdata=0xABABABAB, we=1; wb_valid 2 cycles after capture.
- Load signed byte: addr=0x102, rdata=0x0080_0000 → wb_regcData=0xFFFFFF80. Same access with ex_ld_unsigned=1 → 0x00000080.
- Load half with gnt delayed 3 cycles and rvalid 2 cycles later: addr=0x202, rdata=0x8001_0000 → req held stable the whole time, mem_busy high throughout, wb_regcData=0xFFFF8001.
- Misaligned word load at 0x101 → no dbus_req; misalign=1, wb_valid=1, wb_regcWr=0 one cycle later.
- rst asserted while in WAIT → next cycle all outputs 0 and state IDLE; a subsequent rvalid produces no wb_valid.
